// File: rtl/attn_token_precision_unit.sv
// Per-key-token precision assignment from a streamed softmaxed attention matrix.
// Latency: the first code is valid the cycle after the last A beat; then one code per cycle.
// Backpressure: a_ready is high only in ACCUM; while prec_ready is low, prec_code and prec_idx hold.
module attn_token_precision_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int ACC_WIDTH  = 24,
  parameter int THR_LO     = 100,
  parameter int THR_HI     = 200,
  localparam int IDX_W     = (L > 1) ? $clog2(L) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [3:0]            prec_code,
  output logic [IDX_W-1:0]      prec_idx,
  output logic                  prec_valid,
  input  logic                  prec_ready,
  output logic [4*L-1:0]        prec_vec,
  output logic                  busy,
  output logic                  done
);

  localparam int ROWS  = L * N;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ACC_WIDTH-1:0] SAT_MAX  = '1;
  localparam logic [ACC_WIDTH:0]   THR_LO_X = (ACC_WIDTH+1)'(THR_LO);
  localparam logic [ACC_WIDTH:0]   THR_HI_X = (ACC_WIDTH+1)'(THR_HI);
  localparam logic [IDX_W-1:0]     COL_LAST = IDX_W'(L - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ACC_WIDTH-1:0] col_sum [L];
  logic [IDX_W-1:0]     col_cnt;
  logic [ROW_W-1:0]     row_cnt;
  logic [4*L-1:0]       shadow_vec;
  logic [4*L-1:0]       vec_upd;

  logic                 beat;
  logic                 last_beat;
  logic                 hs;
  logic                 last_hs;
  logic [IDX_W-1:0]     next_idx;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic [ACC_WIDTH-1:0] first_sum;

  // Map a column sum onto its precision code (0=INT4, 1=INT8, 2=FP16).
  function automatic logic [3:0] code_of(input logic [ACC_WIDTH-1:0] s);
    if ({1'b0, s} < THR_LO_X)      return 4'd0;
    else if ({1'b0, s} < THR_HI_X) return 4'd1;
    else                           return 4'd2;
  endfunction

  assign beat      = a_valid && a_ready;
  assign last_beat = beat && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  assign hs        = prec_valid && prec_ready;
  assign last_hs   = hs && (prec_idx == COL_LAST);
  assign next_idx  = prec_idx + IDX_W'(1);

  // One bit of headroom catches the carry that signals saturation.
  assign sum_ext   = {1'b0, col_sum[col_cnt]} + {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, a_data};
  assign sat_sum   = sum_ext[ACC_WIDTH] ? SAT_MAX : sum_ext[ACC_WIDTH-1:0];
  // Column 0 is only still changing on the final beat when L==1.
  assign first_sum = (col_cnt == '0) ? sat_sum : col_sum[0];

  // Merge the code currently on the output into the partially built vector.
  always_comb begin
    vec_upd = shadow_vec;
    vec_upd[4*prec_idx +: 4] = prec_code;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    a_ready    = 1'b0;
    prec_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        a_ready = 1'b1;
        if (last_beat) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        prec_valid = 1'b1;
        if (last_hs) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Column accumulation, code generation and result vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) col_sum[i] <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      prec_idx   <= '0;
      prec_code  <= '0;
      shadow_vec <= '0;
      prec_vec   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < L; i++) col_sum[i] <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            shadow_vec <= '0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            col_sum[col_cnt] <= sat_sum;
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + ROW_W'(1);
            end else begin
              col_cnt <= col_cnt + IDX_W'(1);
            end
          end
          if (last_beat) begin
            row_cnt   <= '0;
            prec_idx  <= '0;
            prec_code <= code_of(first_sum);
          end
        end
        S_EMIT: begin
          if (hs) begin
            shadow_vec <= vec_upd;
            if (last_hs) begin
              prec_vec <= vec_upd;
            end else begin
              prec_idx  <= next_idx;
              prec_code <= code_of(col_sum[next_idx]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
